program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Byte-stream program loader that sits directly upstream of the instruction ROM.
- Receives framed program images over a valid/ready byte interface and converts each code byte into a ROM write, driving the ROM's edit/unit/code/send programming inputs.
- Holds the CPU in reset while loading; reports completion and checksum/framing errors.

Parameters:
- HEADER, 8'hA5, frame start byte
- MAX_LEN, 255, largest accepted payload length; a LEN byte above this is a framing error
- TIMEOUT_CYCLES, 1024, idle-cycle limit mid-frame (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  input byte valid
- in_data  in  8  input byte
- in_ready  out  1  loader can accept in_data this cycle
- edit  out  1  ROM programming-mode enable
- unit  out  8  ROM write address
- code  out  8  ROM write data
- send  out  1  one-cycle ROM write strobe
- cpu_hold  out  1  held high while a frame is in progress; intended to OR into the CPU rst
- done  out  1  one-cycle pulse when a frame completes with a good checksum
- error  out  1  sticky error flag; cleared on acceptance of the next HEADER byte
- busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, on rst.
- Reset values: state=IDLE; in_ready=1; edit, send, cpu_hold, done, error, busy = 0; unit=0; code=0; internal len, cnt and sum = 0.
- Byte acceptance: a byte is accepted on any rising edge where in_valid && in_ready. in_data is sampled only on acceptance.
- Frame format: HEADER, LEN, ADDR, LEN data bytes, CSUM. CSUM is the sum of the data bytes mod 256.
- FSM states and transitions:
  - IDLE: non-HEADER bytes are accepted and discarded. On HEADER: go to LEN, clear error, set busy and cpu_hold.
  - LEN: store len. If LEN > MAX_LEN: set error, go to IDLE. Otherwise go to ADDR.
  - ADDR: unit <= in_data; cnt <= 0; sum <= 0; edit <= 1. Go to DATA, or to CSUM if len==0.
  - DATA: code <= in_data; sum <= sum + in_data (8-bit wrap); go to WRITE.
  - WRITE: in_ready=0; send=1 for exactly this cycle; unit and code stable. Next cycle: unit <= unit+1 (wraps 255->0), cnt <= cnt+1. Go to DATA if cnt+1 < len, else to CSUM.
  - CSUM: on byte, compare with sum. Match: pulse done. Mismatch: set error. Either way go to IDLE, and drop edit, cpu_hold and busy the following cycle.
- ROM write throughput: one data byte per 2 cycles minimum. in_ready is low only in WRITE.
- Edit window: edit rises the cycle after ADDR acceptance and falls on the return to IDLE. send is never high while edit is low.
- Bad checksum: ROM contents are already written and are not rolled back. error stays set until the next HEADER byte.
- Reset mid-frame: immediately returns to IDLE with all outputs at reset values; ROM keeps the partial image.
- HEADER value inside a frame: treated as ordinary data (no resync).

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- When defined: a counter clears on every accepted byte and increments each cycle while state is not IDLE. On reaching TIMEOUT_CYCLES: set error, go to IDLE, drop edit and cpu_hold.
- When undefined: no counter is present; the loader waits indefinitely mid-frame.

Decomposition:
- Package loader_pkg holds:
  - state enum (IDLE, LEN, ADDR, DATA, WRITE, CSUM)
  - HEADER default constant
  - byte typedef (8-bit)
- Sub-module loader_watchdog (timeout counter) is natural. It is instantiated only under LOADER_TIMEOUT_EN.

Test Plan:
- Good frame A5,03,10,11,22,33,66: three send pulses with unit/code = 10/11, 11/22, 12/33; done pulses once; error=0; edit low afterwards.
- Bad checksum A5,02,00,01,02,00: two writes occur; error=1 and stays 1; no done; next A5 clears error.
- Address wrap A5,02,FF,AA,BB,65: writes at unit FF then 00.
- Zero length A5,00,40,00: no send; done pulses. Garbage bytes 00,FF before A5 are ignored.
- Backpressure and reset: in_valid held high on every cycle: in_ready low during each WRITE, with no byte lost or duplicated. Asserting rst after the 2nd data byte: all outputs return to 0 and in_ready to 1 asynchronously.
- LOADER_TIMEOUT_EN with TIMEOUT_CYCLES=16: stall 16 cycles after the LEN byte; error=1, busy=0, cpu_hold=0.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader (states, byte type, default frame header).
package loader_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t HEADER_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    ADDR,
    DATA,
    WRITE,
    CSUM
  } state_t;

endpackage

// File: rtl/loader_watchdog.sv
// Mid-frame idle watchdog: counts cycles since the last accepted byte while a frame is open.
module loader_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic kick,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  assign expired = active && (count == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!active || kick) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader driving the instruction ROM's edit/unit/code/send write port.
// Optional mid-frame timeout is built in when LOADER_TIMEOUT_EN is defined.
module program_loader
  import loader_pkg::*;
#(
  parameter byte_t       HEADER         = HEADER_DEFAULT,
  parameter int unsigned MAX_LEN        = 255,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       edit,
  output logic [7:0] unit,
  output logic [7:0] code,
  output logic       send,
  output logic       cpu_hold,
  output logic       done,
  output logic       error,
  output logic       busy
);

  state_t state, state_n;
  byte_t  len, len_n;
  byte_t  cnt, cnt_n;
  byte_t  sum, sum_n;
  byte_t  unit_n, code_n;
  logic   edit_n, done_n, error_n;
  logic   accept;
  logic   timeout;
  logic [8:0] cnt_inc;

  assign accept   = in_valid && in_ready;
  assign in_ready = (state != WRITE);
  assign send     = (state == WRITE);
  assign busy     = (state != IDLE);
  assign cpu_hold = busy;

`ifdef LOADER_TIMEOUT_EN
  loader_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .active (state != IDLE),
    .kick   (accept),
    .expired(timeout)
  );
`else
  logic timeout_unused;
  assign timeout_unused = ^TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_n = state;
    len_n   = len;
    cnt_n   = cnt;
    sum_n   = sum;
    unit_n  = unit;
    code_n  = code;
    edit_n  = edit;
    done_n  = 1'b0;
    error_n = error;
    cnt_inc = {1'b0, cnt} + 9'd1;

    case (state)
      IDLE: begin
        if (accept && in_data == HEADER) begin
          state_n = LEN;
          error_n = 1'b0;
        end
      end
      LEN: begin
        if (accept) begin
          len_n = in_data;
          if (32'(in_data) > MAX_LEN) begin
            error_n = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = ADDR;
          end
        end
      end
      ADDR: begin
        if (accept) begin
          unit_n  = in_data;
          cnt_n   = '0;
          sum_n   = '0;
          edit_n  = 1'b1;
          state_n = (len == '0) ? CSUM : DATA;
        end
      end
      DATA: begin
        if (accept) begin
          code_n  = in_data;
          sum_n   = sum + in_data;
          state_n = WRITE;
        end
      end
      WRITE: begin
        unit_n  = unit + 8'd1;
        cnt_n   = cnt_inc[7:0];
        state_n = (cnt_inc < {1'b0, len}) ? DATA : CSUM;
      end
      CSUM: begin
        if (accept) begin
          if (in_data == sum) done_n = 1'b1;
          else                error_n = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (timeout) begin
      state_n = IDLE;
      error_n = 1'b1;
    end

    // the edit window closes on every path back to IDLE, including error and timeout exits
    if (state_n == IDLE) edit_n = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      len   <= '0;
      cnt   <= '0;
      sum   <= '0;
      unit  <= '0;
      code  <= '0;
      edit  <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_n;
      len   <= len_n;
      cnt   <= cnt_n;
      sum   <= sum_n;
      unit  <= unit_n;
      code  <= code_n;
      edit  <= edit_n;
      done  <= done_n;
      error <= error_n;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: frame-level reference model, per-cycle compare, directed + random frames.
module tb_program_loader;

  localparam logic [7:0] HDR  = 8'hA5;
  localparam int         MAXL = 200;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, edit, send, cpu_hold, done, error, busy;
  logic [7:0] unit, code;

  always #5 clk = ~clk;

  program_loader #(
    .HEADER        (HDR),
    .MAX_LEN       (MAXL),
    .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .edit    (edit),
    .unit    (unit),
    .code    (code),
    .send    (send),
    .cpu_hold(cpu_hold),
    .done    (done),
    .error   (error),
    .busy    (busy)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model: frame parser by byte position ----------------
  logic       e_ready = 1'b1, e_send = 1'b0, e_edit = 1'b0, e_busy = 1'b0;
  logic       e_done = 1'b0, e_error = 1'b0;
  logic [7:0] e_unit = 8'h00, e_code = 8'h00;
  int         pos = 0, flen = 0, fsum = 0;
  bit         m_acc = 1'b0;
  int         m_done = 0;
  bq_t        mw_a, mw_d;
  logic       acc, was_send;
  logic [7:0] b;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e_ready = 1'b1; e_send = 1'b0; e_edit = 1'b0; e_busy = 1'b0;
      e_done = 1'b0; e_error = 1'b0; e_unit = 8'h00; e_code = 8'h00;
      pos = 0; m_acc = 1'b0;
    end else begin
      acc      = in_valid && e_ready;
      b        = in_data;
      was_send = e_send;
      m_acc    = acc;
      e_send   = 1'b0;
      e_done   = 1'b0;
      e_ready  = 1'b1;
      if (was_send) e_unit = e_unit + 8'd1;
      if (acc) begin
        if (pos == 0) begin
          if (b == HDR) begin pos = 1; e_error = 1'b0; e_busy = 1'b1; end
        end else if (pos == 1) begin
          flen = int'(b);
          if (flen > MAXL) begin e_error = 1'b1; e_busy = 1'b0; pos = 0; end
          else pos = 2;
        end else if (pos == 2) begin
          e_unit = b; e_edit = 1'b1; fsum = 0; pos = 3;
        end else if (pos < 3 + flen) begin
          e_code = b; fsum = (fsum + int'(b)) % 256;
          e_send = 1'b1; e_ready = 1'b0;
          mw_a.push_back(e_unit); mw_d.push_back(b);
          pos++;
        end else begin
          if (int'(b) == fsum) begin e_done = 1'b1; m_done++; end
          else e_error = 1'b1;
          pos = 0; e_busy = 1'b0; e_edit = 1'b0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bq_t d_a, d_d;
  int  d_done = 0;

  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(e_ready));
    chk("send",     32'(send),     32'(e_send));
    chk("edit",     32'(edit),     32'(e_edit));
    chk("unit",     32'(unit),     32'(e_unit));
    chk("code",     32'(code),     32'(e_code));
    chk("cpu_hold", 32'(cpu_hold), 32'(e_busy));
    chk("busy",     32'(busy),     32'(e_busy));
    chk("done",     32'(done),     32'(e_done));
    chk("error",    32'(error),    32'(e_error));
    if (send) begin d_a.push_back(unit); d_d.push_back(code); end
    if (done) d_done++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic put(input logic [7:0] v, input bit gaps);
    int n;
    if (gaps) begin
      int g;
      g = $urandom_range(0, 2);
      repeat (g) begin in_valid = 1'b0; @(negedge clk); #1; end
    end
    in_valid = 1'b1;
    in_data  = v;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!m_acc && n < 40);
    if (!m_acc) begin
      total++;
      $display("FAIL accept_timeout: byte 0x%0h not accepted, expected acceptance within 40 cycles", v);
    end
  endtask

  task automatic put_seq(input bq_t s, input bit gaps);
    foreach (s[i]) put(s[i], gaps);
  endtask

  task automatic clear_logs();
    d_a.delete(); d_d.delete(); mw_a.delete(); mw_d.delete();
    d_done = 0; m_done = 0;
  endtask

  task automatic check_log(input string tag, input bq_t xa, input bq_t xd, input int nd, input logic err);
    chk({tag, "_nwr"},       d_a.size(),  xa.size());
    chk({tag, "_model_nwr"}, mw_a.size(), xa.size());
    foreach (xa[i]) begin
      if (i < d_a.size()) begin
        chk($sformatf("%s_unit%0d", tag, i), 32'(d_a[i]), 32'(xa[i]));
        chk($sformatf("%s_code%0d", tag, i), 32'(d_d[i]), 32'(xd[i]));
      end
      if (i < mw_a.size()) begin
        chk($sformatf("%s_model_unit%0d", tag, i), 32'(mw_a[i]), 32'(xa[i]));
        chk($sformatf("%s_model_code%0d", tag, i), 32'(mw_d[i]), 32'(xd[i]));
      end
    end
    chk({tag, "_done"},        d_done, nd);
    chk({tag, "_model_done"},  m_done, nd);
    chk({tag, "_error"},       32'(error),   32'(err));
    chk({tag, "_model_error"}, 32'(e_error), 32'(err));
    chk({tag, "_busy"},        32'(busy), 0);
    chk({tag, "_edit"},        32'(edit), 0);
  endtask

  task automatic rand_frame(input int len, input bit gaps);
    bq_t s;
    logic [7:0] addr, d, sum;
    int ng;
    ng = $urandom_range(0, 2);
    repeat (ng) begin
      d = 8'($urandom_range(0, 255));
      if (d == HDR) d = 8'h5A;
      s.push_back(d);
    end
    addr = ($urandom_range(0, 3) == 0) ? 8'(32'hFC + $urandom_range(0, 3)) : 8'($urandom_range(0, 255));
    s.push_back(HDR); s.push_back(8'(len)); s.push_back(addr);
    sum = 8'h00;
    for (int i = 0; i < len; i++) begin
      d = 8'($urandom_range(0, 255));
      s.push_back(d);
      sum = sum + d;
    end
    if ($urandom_range(0, 4) == 0) sum = sum + 8'($urandom_range(1, 255));
    s.push_back(sum);
    put_seq(s, gaps);
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "global timeout");
  end

  // ---------------- main sequence ----------------
  bq_t s, xa, xd;

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_busy",     32'(busy),     0);
    chk("rst_unit",     32'(unit),     0);
    chk("rst_error",    32'(error),    0);
    rst = 1'b0;
    idle(2);

    // good frame preceded by garbage, in_valid held high throughout
    clear_logs();
    s = '{8'h00, 8'hFF, 8'hA5, 8'h03, 8'h10, 8'h11, 8'h22, 8'h33, 8'h66};
    put_seq(s, 1'b0);
    idle(3);
    xa = '{8'h10, 8'h11, 8'h12}; xd = '{8'h11, 8'h22, 8'h33};
    check_log("good", xa, xd, 1, 1'b0);

    // bad checksum: writes stay, error sticky
    clear_logs();
    s = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h00};
    put_seq(s, 1'b0);
    idle(3);
    xa = '{8'h00, 8'h01}; xd = '{8'h01, 8'h02};
    check_log("badsum", xa, xd, 0, 1'b1);
    idle(6);
    chk("badsum_sticky", 32'(error), 1);

    // address wrap; the header clears the sticky error
    clear_logs();
    s = '{8'hA5, 8'h02, 8'hFF, 8'hAA, 8'hBB, 8'h65};
    put_seq(s, 1'b1);
    idle(3);
    xa = '{8'hFF, 8'h00}; xd = '{8'hAA, 8'hBB};
    check_log("wrap", xa, xd, 1, 1'b0);

    // zero length after garbage
    clear_logs();
    s = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h40, 8'h00};
    put_seq(s, 1'b0);
    idle(3);
    xa.delete(); xd.delete();
    check_log("zerolen", xa, xd, 1, 1'b0);

    // asynchronous reset right after the 2nd data byte, during its WRITE cycle
    clear_logs();
    s = '{8'hA5, 8'h04, 8'h20, 8'h01, 8'h02};
    put_seq(s, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_in_ready", 32'(in_ready), 1);
    chk("arst_send",     32'(send),     0);
    chk("arst_edit",     32'(edit),     0);
    chk("arst_unit",     32'(unit),     0);
    chk("arst_code",     32'(code),     0);
    chk("arst_cpu_hold", 32'(cpu_hold), 0);
    chk("arst_busy",     32'(busy),     0);
    chk("arst_done",     32'(done),     0);
    chk("arst_error",    32'(error),    0);
    @(negedge clk); #1;
    rst = 1'b0;
    idle(2);

    // LEN one above the limit is a framing error
    clear_logs();
    s = '{8'hA5, 8'(MAXL + 1)};
    put_seq(s, 1'b0);
    idle(3);
    xa.delete(); xd.delete();
    check_log("overlen", xa, xd, 0, 1'b1);

    // LEN exactly at the limit is accepted
    clear_logs();
    rand_frame(MAXL, 1'b0);
    idle(3);
    chk("maxlen_nwr", d_a.size(), MAXL);

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      rand_frame($urandom_range(0, 8), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
